// File: rtl/uart_frame_loader_if.sv
// rtl/uart_frame_loader_if.sv - byte-strobe input and memory/status output bundle for uart_frame_loader
//
// Signals:
//   rx_valid, rx_data          : byte strobe from the UART receiver
//   mem_we, mem_addr, mem_wdata: RAM write port
//   busy, done, error          : frame status towards the core
//   error_code, frame_len      : held result of the last frame
// Modports:
//   master : drives the byte strobe, observes the loader outputs
//   slave  : the loader itself
interface uart_frame_loader_if #(
    parameter int AddrWidth = 10
);
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 mem_we;
    logic [AddrWidth-1:0] mem_addr;
    logic [7:0]           mem_wdata;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [1:0]           error_code;
    logic [AddrWidth:0]   frame_len;

    modport master (
        output rx_valid, rx_data,
        input  mem_we, mem_addr, mem_wdata, busy, done, error, error_code, frame_len
    );

    modport slave (
        input  rx_valid, rx_data,
        output mem_we, mem_addr, mem_wdata, busy, done, error, error_code, frame_len
    );
endinterface

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - parses framed UART byte streams into RAM writes
//
// Frame: SyncByte, len[15:8], len[7:0], len payload bytes, 8-bit additive checksum.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : uart_frame_loader_if.slave (byte strobe in, RAM write and status out)
// All outputs are registered.
module uart_frame_loader #(
    parameter int          AddrWidth     = 10,
    parameter int          MaxLength     = 1024,
    parameter logic [7:0]  SyncByte      = 8'hA5,
    parameter int          TimeoutCycles = 120000
) (
    input logic                clk,
    input logic                reset,
    uart_frame_loader_if.slave bus
);

    localparam int LenW = AddrWidth + 1;
    localparam int TmoW = $clog2(TimeoutCycles + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           len_hi_q, len_hi_d;
    logic [LenW-1:0]      len_q, len_d;
    logic [LenW-1:0]      idx_q, idx_d;
    logic [7:0]           csum_q, csum_d;
    logic [TmoW-1:0]      tmo_q, tmo_d;
    logic [1:0]           error_code_q, error_code_d;
    logic [LenW-1:0]      frame_len_q, frame_len_d;

    logic                 mem_we_q, mem_we_d;
    logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic [15:0]          len_full;
    logic                 tmo_run;
    logic                 tmo_expired;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            len_hi_q     <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            tmo_q        <= '0;
            error_code_q <= '0;
            frame_len_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            tmo_q        <= tmo_d;
            error_code_q <= error_code_d;
            frame_len_q  <= frame_len_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign len_full = {len_hi_q, bus.rx_data};
    assign tmo_run  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_expired = tmo_run && !bus.rx_valid &&
                         (tmo_q == TmoW'(TimeoutCycles - 1));

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        len_d        = len_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        error_code_d = error_code_q;
        frame_len_d  = frame_len_q;
        // Cleared on every byte; entry to LEN_HI is always via a byte.
        tmo_d        = (!tmo_run || bus.rx_valid) ? '0 : tmo_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SyncByte) begin
                    state_d      = S_LEN_HI;
                    error_code_d = 2'd0;
                    csum_d       = '0;
                    idx_d        = '0;
                end
            end
            S_LEN_HI: begin
                if (bus.rx_valid) begin
                    len_hi_d = bus.rx_data;
                    state_d  = S_LEN_LO;
                end else if (tmo_expired) begin
                    state_d      = S_ERROR;
                    error_code_d = 2'd3;
                end
            end
            S_LEN_LO: begin
                if (bus.rx_valid) begin
                    if (len_full > 16'(MaxLength)) begin
                        state_d      = S_ERROR;
                        error_code_d = 2'd2;
                    end else begin
                        len_d   = len_full[LenW-1:0];
                        state_d = (len_full == 16'd0) ? S_CHECK : S_PAYLOAD;
                    end
                end else if (tmo_expired) begin
                    state_d      = S_ERROR;
                    error_code_d = 2'd3;
                end
            end
            S_PAYLOAD: begin
                if (bus.rx_valid) begin
                    csum_d = csum_q + bus.rx_data;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q + 1'b1 == len_q) begin
                        state_d = S_CHECK;
                    end
                end else if (tmo_expired) begin
                    state_d      = S_ERROR;
                    error_code_d = 2'd3;
                end
            end
            S_CHECK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        state_d     = S_DONE;
                        frame_len_d = len_q;
                    end else begin
                        state_d      = S_ERROR;
                        error_code_d = 2'd1;
                    end
                end else if (tmo_expired) begin
                    state_d      = S_ERROR;
                    error_code_d = 2'd3;
                end
            end
            // Any byte seen during the DONE/ERROR cycle is dropped.
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-values, registered alongside the state
    always_comb begin
        mem_we_d    = (state_q == S_PAYLOAD) && bus.rx_valid;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (mem_we_d) begin
            mem_addr_d  = idx_q[AddrWidth-1:0];
            mem_wdata_d = bus.rx_data;
        end
        busy_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                  (state_d == S_PAYLOAD) || (state_d == S_CHECK);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERROR);
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.error_code = error_code_q;
    assign bus.frame_len  = frame_len_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - self-checking bench for uart_frame_loader
module tb_uart_frame_loader;

    localparam int AW = 10;
    localparam int ML = 1024;
    localparam int T  = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_frame_loader_if #(.AddrWidth(AW)) bus();

    uart_frame_loader #(
        .AddrWidth(AW),
        .MaxLength(ML),
        .SyncByte(8'hA5),
        .TimeoutCycles(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int          n;
        logic [63:0] b;
        int          pay;
        int          nw;
        int          dec;
        int          exp_done;
        int          exp_err;
        int          code;
        int          flen;
    } vec_t;

    int  n_pass  = 0;
    int  n_total = 0;
    int  ncyc    = 0;
    int  rx_q[$];
    wr_t wr_q[$];
    int  done_cnt = 0;
    int  err_cnt  = 0;
    int  done_cyc = -1;
    int  err_cyc  = -1;

    always @(negedge clk) begin
        ncyc++;
        if (bus.rx_valid) rx_q.push_back(ncyc);
        if (bus.mem_we) wr_q.push_back('{ncyc, int'(bus.mem_addr), int'(bus.mem_wdata)});
        if (bus.done) begin
            done_cnt++;
            done_cyc = ncyc;
        end
        if (bus.error) begin
            err_cnt++;
            err_cyc = ncyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic clear_logs();
        rx_q.delete();
        wr_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    // Called at posedge+1; leaves rx_valid low for 'gap' full cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vt[6];

    initial begin
        vec_t       cv;
        logic [7:0] lb;
        int         bad;
        int         waited;

        vt[0] = '{7, 64'hA5_00_03_11_22_33_66_00, 3, 3, 6, 1, 0, 0, 3};
        vt[1] = '{6, 64'hA5_00_02_10_20_31_00_00, 3, 2, 5, 0, 1, 1, 3};
        vt[2] = '{4, 64'hA5_04_01_55_00_00_00_00, 3, 0, 2, 0, 1, 2, 3};
        vt[3] = '{4, 64'hA5_00_00_00_00_00_00_00, 3, 0, 3, 1, 0, 0, 0};
        vt[4] = '{7, 64'h00_FF_A5_00_01_7F_7F_00, 5, 1, 6, 1, 0, 0, 1};
        vt[5] = '{6, 64'hA5_00_02_A5_01_A6_00_00, 3, 2, 5, 1, 0, 0, 2};

        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(3);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_outputs", int'({bus.mem_we, bus.done, bus.error, bus.error_code}), 0);
        check("reset_frame_len", int'(bus.frame_len), 0);
        reset = 1'b1;
        idle(2);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            cv = vt[v];
            clear_logs();
            for (int i = 0; i < cv.n; i++) begin
                lb = cv.b[63-8*i -: 8];
                send_byte(lb, 2);
            end
            idle(6);
            check($sformatf("v%0d_rx_count", v), rx_q.size(), cv.n);
            check($sformatf("v%0d_writes", v), wr_q.size(), cv.nw);
            if (wr_q.size() == cv.nw && rx_q.size() == cv.n) begin
                for (int j = 0; j < cv.nw; j++) begin
                    lb = cv.b[63-8*(cv.pay+j) -: 8];
                    check($sformatf("v%0d_w%0d_addr", v, j), wr_q[j].addr, j);
                    check($sformatf("v%0d_w%0d_data", v, j), wr_q[j].data, int'(lb));
                    check($sformatf("v%0d_w%0d_latency", v, j), wr_q[j].cyc - rx_q[cv.pay+j], 1);
                end
                if (cv.exp_done != 0)
                    check($sformatf("v%0d_done_latency", v), done_cyc - rx_q[cv.dec], 1);
                else
                    check($sformatf("v%0d_err_latency", v), err_cyc - rx_q[cv.dec], 1);
            end
            check($sformatf("v%0d_done_cnt", v), done_cnt, cv.exp_done);
            check($sformatf("v%0d_err_cnt", v), err_cnt, cv.exp_err);
            check($sformatf("v%0d_error_code", v), int'(bus.error_code), cv.code);
            check($sformatf("v%0d_frame_len", v), int'(bus.frame_len), cv.flen);
            check($sformatf("v%0d_busy", v), int'(bus.busy), 0);
        end

        // Timeout: a byte on the expiry cycle wins, then silence times out
        clear_logs();
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'hA5, 2);
        send_byte(8'h00, 2);
        send_byte(8'h05, 2);
        send_byte(8'h01, T - 1);
        send_byte(8'h02, 0);
        idle(3);
        check("tmo_byte_wins_no_err", err_cnt, 0);
        check("tmo_busy_mid_frame", int'(bus.busy), 1);
        waited = 0;
        while (err_cnt == 0 && waited < T + 20) begin
            idle(1);
            waited++;
        end
        idle(2);
        check("tmo_err_cnt", err_cnt, 1);
        if (rx_q.size() > 0)
            check("tmo_err_delay", err_cyc - rx_q[rx_q.size()-1], T + 1);
        check("tmo_error_code", int'(bus.error_code), 3);
        check("tmo_busy_dropped", int'(bus.busy), 0);
        check("tmo_writes", wr_q.size(), 2);
        check("tmo_done_cnt", done_cnt, 0);

        // Asynchronous reset mid-payload
        clear_logs();
        send_byte(8'hA5, 2);
        send_byte(8'h00, 2);
        send_byte(8'h04, 2);
        send_byte(8'h01, 2);
        send_byte(8'h02, 2);
        check("rst_writes_before", wr_q.size(), 2);
        check("rst_busy_before", int'(bus.busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_busy_async", int'(bus.busy), 0);
        check("rst_frame_len_async", int'(bus.frame_len), 0);
        check("rst_error_code_async", int'(bus.error_code), 0);
        check("rst_outputs_async", int'({bus.mem_we, bus.done, bus.error}), 0);
        idle(2);
        #2;
        reset = 1'b1;
        idle(3);
        check("rst_no_done", done_cnt, 0);
        check("rst_no_err", err_cnt, 0);
        clear_logs();
        send_byte(8'hA5, 2);
        send_byte(8'h00, 2);
        send_byte(8'h01, 2);
        send_byte(8'h7F, 2);
        send_byte(8'h7F, 2);
        idle(4);
        check("post_rst_done", done_cnt, 1);
        check("post_rst_frame_len", int'(bus.frame_len), 1);
        check("post_rst_writes", wr_q.size(), 1);
        if (wr_q.size() == 1) begin
            check("post_rst_addr", wr_q[0].addr, 0);
            check("post_rst_data", wr_q[0].data, 8'h7F);
        end

        // Largest accepted length, back-to-back bytes; sum of 4x(0..255) is 0 mod 256
        clear_logs();
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < ML; i++) send_byte(8'(i), 0);
        send_byte(8'h00, 0);
        idle(5);
        check("max_writes", wr_q.size(), ML);
        bad = 0;
        if (wr_q.size() == ML && rx_q.size() == ML + 4) begin
            for (int i = 0; i < ML; i++) begin
                if (wr_q[i].addr != i || wr_q[i].data != (i % 256) ||
                    wr_q[i].cyc != rx_q[3+i] + 1) bad++;
            end
            check("max_last_addr", wr_q[ML-1].addr, ML - 1);
        end
        check("max_bad_writes", bad, 0);
        check("max_done", done_cnt, 1);
        check("max_err", err_cnt, 0);
        check("max_frame_len", int'(bus.frame_len), ML);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
